traffic_conflict_monitor: RTL and testbench

- Downstream safety stage for the 4-way traffic light controller. Consumes its per-road lamp codes r1..r4 and drives the physical lamp commands l1..l4.
- In normal operation it forwards the codes with one cycle of registered latency and checks them every cycle for conflicts, illegal sequences and timing violations.
- On any violation it latches a fault and forces all roads to flashing red until the fault is acknowledged.

---
 rtl/traffic_conflict_monitor.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Safety stage placed between the 4-way traffic light controller and the
// physical lamp drivers. In NORMAL it forwards the controller's lamp codes
// with one registered cycle of latency and checks every cycle for:
//   - invalid codes
//   - conflicting greens/yellows
//   - illegal colour sequences
//   - minimum green, yellow and all-red dwell times
// Any violation latches a fault code and forces all roads to flashing red
// until the fault is acknowledged. The monitor then waits for a settled
// all-red period before it resumes forwarding.
//
// Lamp encoding: 00 RED, 01 YELLOW, 10 GREEN, 11 invalid (inputs) / DARK
// (outputs).
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   r1..r4 [1:0]   lamp codes from the controller
//   clear          fault acknowledge, only looked at while faulted
//   l1..l4 [1:0]   registered lamp commands
//   fault          high while in FAULT
//   fault_code[2:0] first violation:
//                    0 none, 1 INVALID, 2 CONFLICT, 3 BAD_SEQ,
//                    4 SHORT_GREEN, 5 SHORT_YELLOW, 6 SHORT_ALLRED
//   fault_road[1:0] offending road index (0 = road 1)
//
// Optional feature, enabled by defining the macro FAULT_COUNT_EN:
//   fault_count[7:0]  saturating count of NORMAL->FAULT entries.
//                     It is not affected by clear.
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int MIN_GREEN   = 5,
    parameter int MIN_YELLOW  = 2,
    parameter int MIN_ALL_RED = 2,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] r1,
    input  logic [1:0] r2,
    input  logic [1:0] r3,
    input  logic [1:0] r4,
    input  logic       clear,
    output logic [1:0] l1,
    output logic [1:0] l2,
    output logic [1:0] l3,
    output logic [1:0] l4,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_road
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    // Dwell and all-red counters saturate at the largest minimum they are
    // compared against.
    localparam int SAT_GY  = (MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW;
    localparam int SAT_MAX = (SAT_GY > MIN_ALL_RED) ? SAT_GY : MIN_ALL_RED;
    localparam int CW      = $clog2(SAT_MAX) + 1;
    localparam int FW      = $clog2(FLASH_HALF) + 1;

    localparam logic [CW-1:0] SAT_V        = CW'(SAT_MAX);
    localparam logic [CW-1:0] ONE_V        = CW'(1);
    localparam logic [CW-1:0] ZERO_V       = CW'(0);
    localparam logic [CW-1:0] MIN_GREEN_V  = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MIN_YELLOW_V = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] MIN_ALLRED_V = CW'(MIN_ALL_RED);
    localparam logic [FW-1:0] FLASH_LAST_V = FW'(FLASH_HALF - 1);
    localparam logic [FW-1:0] FLASH_ZERO_V = FW'(0);
    localparam logic [FW-1:0] FLASH_ONE_V  = FW'(1);

    localparam logic [1:0] C_RED  = 2'b00;
    localparam logic [1:0] C_YEL  = 2'b01;
    localparam logic [1:0] C_GRN  = 2'b10;
    localparam logic [1:0] C_INV  = 2'b11;
    localparam logic [1:0] C_DARK = 2'b11;

    localparam logic [2:0] F_NONE    = 3'd0;
    localparam logic [2:0] F_INVALID = 3'd1;
    localparam logic [2:0] F_CONFLICT = 3'd2;
    localparam logic [2:0] F_BADSEQ  = 3'd3;
    localparam logic [2:0] F_SGREEN  = 3'd4;
    localparam logic [2:0] F_SYELLOW = 3'd5;
    localparam logic [2:0] F_SALLRED = 3'd6;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Saturating increment shared by the dwell, all-red and recover counters.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] res;
        if (v >= SAT_V) begin
            res = SAT_V;
        end else begin
            res = v + ONE_V;
        end
        return res;
    endfunction

    state_t        state_r;
    logic [1:0]    prev_r   [4];
    logic [CW-1:0] dwell_r  [4];
    logic [CW-1:0] allred_r;
    logic [CW-1:0] rec_cnt_r;
    logic [FW-1:0] flash_cnt_r;
    logic          flash_off_r;
    logic [1:0]    lamp_r   [4];

    logic [1:0]    code_s   [4];
    logic          all_red_s;
    logic [2:0]    nonred_cnt_s;
    logic [1:0]    conf_road_s;
    logic          inv_s;
    logic [1:0]    inv_road_s;
    logic          bad_s;
    logic [1:0]    bad_road_s;
    logic          sg_s;
    logic [1:0]    sg_road_s;
    logic          sy_s;
    logic [1:0]    sy_road_s;
    logic          sa_s;
    logic [1:0]    sa_road_s;
    logic          viol_s;
    logic [2:0]    viol_code_s;
    logic [1:0]    viol_road_s;
    logic [CW-1:0] rec_next_s;

    assign code_s[0] = r1;
    assign code_s[1] = r2;
    assign code_s[2] = r3;
    assign code_s[3] = r4;

    assign l1 = lamp_r[0];
    assign l2 = lamp_r[1];
    assign l3 = lamp_r[2];
    assign l4 = lamp_r[3];

    // Per-road rule checks on the current inputs versus the previous codes.
    // Roads are scanned from 3 down to 0 so that the lowest-indexed
    // offender is the value left in each *_road_s.
    always_comb begin
        all_red_s    = 1'b1;
        nonred_cnt_s = 3'd0;
        conf_road_s  = 2'd0;
        inv_s        = 1'b0;
        inv_road_s   = 2'd0;
        bad_s        = 1'b0;
        bad_road_s   = 2'd0;
        sg_s         = 1'b0;
        sg_road_s    = 2'd0;
        sy_s         = 1'b0;
        sy_road_s    = 2'd0;
        sa_s         = 1'b0;
        sa_road_s    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (code_s[i] != C_RED) begin
                all_red_s    = 1'b0;
                nonred_cnt_s = nonred_cnt_s + 3'd1;
                conf_road_s  = 2'(i);
            end else begin
            end
            if (code_s[i] == C_INV) begin
                inv_s      = 1'b1;
                inv_road_s = 2'(i);
            end else begin
            end
            if (((prev_r[i] == C_RED) && (code_s[i] == C_YEL)) ||
                ((prev_r[i] == C_YEL) && (code_s[i] == C_GRN)) ||
                ((prev_r[i] == C_GRN) && (code_s[i] == C_RED))) begin
                bad_s      = 1'b1;
                bad_road_s = 2'(i);
            end else begin
            end
            if ((prev_r[i] == C_GRN) && (code_s[i] == C_YEL) &&
                (dwell_r[i] < MIN_GREEN_V)) begin
                sg_s      = 1'b1;
                sg_road_s = 2'(i);
            end else begin
            end
            if ((prev_r[i] == C_YEL) && (code_s[i] == C_RED) &&
                (dwell_r[i] < MIN_YELLOW_V)) begin
                sy_s      = 1'b1;
                sy_road_s = 2'(i);
            end else begin
            end
            if ((prev_r[i] == C_RED) && (code_s[i] == C_GRN) &&
                (allred_r < MIN_ALLRED_V)) begin
                sa_s      = 1'b1;
                sa_road_s = 2'(i);
            end else begin
            end
        end
    end

    // Priority resolution: the lowest fault code wins.
    always_comb begin
        viol_s      = 1'b1;
        viol_code_s = F_NONE;
        viol_road_s = 2'd0;
        if (inv_s) begin
            viol_code_s = F_INVALID;
            viol_road_s = inv_road_s;
        end else if (nonred_cnt_s > 3'd1) begin
            viol_code_s = F_CONFLICT;
            viol_road_s = conf_road_s;
        end else if (bad_s) begin
            viol_code_s = F_BADSEQ;
            viol_road_s = bad_road_s;
        end else if (sg_s) begin
            viol_code_s = F_SGREEN;
            viol_road_s = sg_road_s;
        end else if (sy_s) begin
            viol_code_s = F_SYELLOW;
            viol_road_s = sy_road_s;
        end else if (sa_s) begin
            viol_code_s = F_SALLRED;
            viol_road_s = sa_road_s;
        end else begin
            viol_s = 1'b0;
        end
    end

    // The recover wait counts the current all-red cycle as well.
    always_comb begin
        rec_next_s = sat_inc(rec_cnt_r);
    end

    // Monitor state machine with registered lamp, fault and history state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_NORMAL;
            fault       <= 1'b0;
            fault_code  <= F_NONE;
            fault_road  <= 2'd0;
            allred_r    <= MIN_ALLRED_V;
            rec_cnt_r   <= ZERO_V;
            flash_cnt_r <= FLASH_ZERO_V;
            flash_off_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                prev_r[i]  <= C_RED;
                dwell_r[i] <= ZERO_V;
                lamp_r[i]  <= C_RED;
            end
`ifdef FAULT_COUNT_EN
            fault_count <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_NORMAL: begin
                    if (viol_s) begin
                        // The offending codes never reach the lamps; the
                        // first flash-ON cycle starts right away.
                        state_r     <= ST_FAULT;
                        fault       <= 1'b1;
                        fault_code  <= viol_code_s;
                        fault_road  <= viol_road_s;
                        flash_cnt_r <= FLASH_ZERO_V;
                        flash_off_r <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            lamp_r[i] <= C_RED;
                        end
`ifdef FAULT_COUNT_EN
                        if (fault_count != 8'hFF) begin
                            fault_count <= fault_count + 8'd1;
                        end else begin
                            fault_count <= fault_count;
                        end
`endif
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            lamp_r[i] <= code_s[i];
                            prev_r[i] <= code_s[i];
                            if (code_s[i] == prev_r[i]) begin
                                dwell_r[i] <= sat_inc(dwell_r[i]);
                            end else begin
                                dwell_r[i] <= ONE_V;
                            end
                        end
                        if (all_red_s) begin
                            allred_r <= sat_inc(allred_r);
                        end else begin
                            allred_r <= ZERO_V;
                        end
                    end
                end

                ST_FAULT: begin
                    if (clear) begin
                        state_r    <= ST_RECOVER;
                        fault      <= 1'b0;
                        fault_code <= F_NONE;
                        fault_road <= 2'd0;
                        rec_cnt_r  <= ZERO_V;
                        for (int i = 0; i < 4; i++) begin
                            lamp_r[i] <= C_RED;
                        end
                    end else if (flash_cnt_r == FLASH_LAST_V) begin
                        // End of a half-period: the lamps take the new phase.
                        flash_cnt_r <= FLASH_ZERO_V;
                        flash_off_r <= ~flash_off_r;
                        for (int i = 0; i < 4; i++) begin
                            lamp_r[i] <= flash_off_r ? C_RED : C_DARK;
                        end
                    end else begin
                        flash_cnt_r <= flash_cnt_r + FLASH_ONE_V;
                        for (int i = 0; i < 4; i++) begin
                            lamp_r[i] <= flash_off_r ? C_DARK : C_RED;
                        end
                    end
                end

                ST_RECOVER: begin
                    for (int i = 0; i < 4; i++) begin
                        lamp_r[i] <= C_RED;
                    end
                    if (!all_red_s) begin
                        rec_cnt_r <= ZERO_V;
                    end else if (rec_next_s >= MIN_ALLRED_V) begin
                        // Settled: resume with a clean history in which an
                        // immediate green is legal.
                        state_r   <= ST_NORMAL;
                        rec_cnt_r <= ZERO_V;
                        allred_r  <= MIN_ALLRED_V;
                        for (int i = 0; i < 4; i++) begin
                            prev_r[i]  <= C_RED;
                            dwell_r[i] <= ZERO_V;
                        end
                    end else begin
                        rec_cnt_r <= rec_next_s;
                    end
                end

                default: begin
                    state_r    <= ST_FAULT;
                    fault      <= 1'b1;
                    fault_code <= F_NONE;
                    fault_road <= 2'd0;
                    for (int i = 0; i < 4; i++) begin
                        lamp_r[i] <= C_RED;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [1:0] r1, r2, r3, r4;
    logic [1:0] l1, l2, l3, l4;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_road;
`ifdef FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif
    logic [7:0] lamps;

    int tests_run    = 0;
    int tests_failed = 0;

    assign lamps = {l1, l2, l3, l4};

    traffic_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .r1         (r1),
        .r2         (r2),
        .r3         (r3),
        .r4         (r4),
        .clear      (clear),
        .l1         (l1),
        .l2         (l2),
        .l3         (l3),
        .l4         (l4),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_road (fault_road)
`ifdef FAULT_COUNT_EN
        ,
        .fault_count(fault_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
        r1 = a;
        r2 = b;
        r3 = c;
        r4 = d;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        clear = 1'b0;
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({fault, fault_code, fault_road, lamps} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected all zero",
                     {fault, fault_code, fault_road, lamps});
        end
    endtask

    task automatic test_legal_cycle();
        logic [7:0] cur;
        logic [1:0] code;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 9; n++) begin
                code = (n < 5) ? 2'b10 : ((n < 7) ? 2'b01 : 2'b00);
                cur = 8'h00;
                cur[7 - 2 * k -: 2] = code;
                set_r(cur[7:6], cur[5:4], cur[3:2], cur[1:0]);
                tick();
                tests_run++;
                if ({fault, lamps} !== {1'b0, cur}) begin
                    tests_failed++;
                    $display("FAIL legal_cycle road%0d step%0d: got %b expected %b",
                             k + 1, n, {fault, lamps}, {1'b0, cur});
                end
            end
        end
    endtask

    task automatic test_conflict();
        logic [7:0] exp_l;
        apply_reset();
        set_r(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        tests_run++;
        if ({fault, fault_code, fault_road, lamps} !== {1'b1, 3'd2, 2'd0, 8'h00}) begin
            tests_failed++;
            $display("FAIL conflict_entry: got %b expected %b",
                     {fault, fault_code, fault_road, lamps}, {1'b1, 3'd2, 2'd0, 8'h00});
        end
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        for (int j = 1; j < 12; j++) begin
            tick();
            exp_l = (((j / 4) % 2) == 1) ? 8'hFF : 8'h00;
            tests_run++;
            if ({fault, fault_code, lamps} !== {1'b1, 3'd2, exp_l}) begin
                tests_failed++;
                $display("FAIL conflict_flash cycle%0d: got %b expected %b",
                         j + 1, {fault, fault_code, lamps}, {1'b1, 3'd2, exp_l});
            end
        end
    endtask

    task automatic test_short_green();
        apply_reset();
        set_r(2'b00, 2'b10, 2'b00, 2'b00);
        for (int j = 0; j < 3; j++) tick();
        tests_run++;
        if ({fault, lamps} !== {1'b0, 8'h20}) begin
            tests_failed++;
            $display("FAIL short_green_hold: got %b expected %b", {fault, lamps}, {1'b0, 8'h20});
        end
        set_r(2'b00, 2'b01, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, fault_code, fault_road, lamps} !== {1'b1, 3'd4, 2'd1, 8'h00}) begin
            tests_failed++;
            $display("FAIL short_green: got %b expected %b",
                     {fault, fault_code, fault_road, lamps}, {1'b1, 3'd4, 2'd1, 8'h00});
        end
    endtask

    task automatic test_short_yellow_allred();
        apply_reset();
        set_r(2'b10, 2'b00, 2'b00, 2'b00);
        for (int j = 0; j < 5; j++) tick();
        set_r(2'b01, 2'b00, 2'b00, 2'b00);
        tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, fault_code, fault_road} !== {1'b1, 3'd5, 2'd0}) begin
            tests_failed++;
            $display("FAIL short_yellow: got %b expected %b",
                     {fault, fault_code, fault_road}, {1'b1, 3'd5, 2'd0});
        end
        apply_reset();
        set_r(2'b10, 2'b00, 2'b00, 2'b00);
        for (int j = 0; j < 5; j++) tick();
        set_r(2'b01, 2'b00, 2'b00, 2'b00);
        for (int j = 0; j < 2; j++) tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        set_r(2'b00, 2'b10, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, fault_code, fault_road} !== {1'b1, 3'd6, 2'd1}) begin
            tests_failed++;
            $display("FAIL short_allred: got %b expected %b",
                     {fault, fault_code, fault_road}, {1'b1, 3'd6, 2'd1});
        end
    endtask

    task automatic test_bad_seq();
        apply_reset();
        set_r(2'b01, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, fault_code, fault_road} !== {1'b1, 3'd3, 2'd0}) begin
            tests_failed++;
            $display("FAIL bad_seq_r_to_y: got %b expected %b",
                     {fault, fault_code, fault_road}, {1'b1, 3'd3, 2'd0});
        end
        apply_reset();
        set_r(2'b00, 2'b00, 2'b00, 2'b10);
        for (int j = 0; j < 5; j++) tick();
        set_r(2'b11, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, fault_code, fault_road} !== {1'b1, 3'd1, 2'd0}) begin
            tests_failed++;
            $display("FAIL priority_invalid: got %b expected %b",
                     {fault, fault_code, fault_road}, {1'b1, 3'd1, 2'd0});
        end
    endtask

    task automatic test_recovery();
        apply_reset();
        set_r(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++;
        if ({fault, fault_code, fault_road, lamps} !== 14'd0) begin
            tests_failed++;
            $display("FAIL recover_clear: got %b expected all zero",
                     {fault, fault_code, fault_road, lamps});
        end
        for (int j = 0; j < 2; j++) begin
            tick();
            tests_run++;
            if ({fault, lamps} !== 9'd0) begin
                tests_failed++;
                $display("FAIL recover_wait%0d: got %b expected 0", j, {fault, lamps});
            end
        end
        set_r(2'b10, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, lamps} !== {1'b0, 8'h80}) begin
            tests_failed++;
            $display("FAIL recover_green: got %b expected %b", {fault, lamps}, {1'b0, 8'h80});
        end
    endtask

    task automatic test_recover_restart();
        apply_reset();
        set_r(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_r(2'b00, 2'b01, 2'b00, 2'b00);
        tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        set_r(2'b10, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, lamps} !== 9'd0) begin
            tests_failed++;
            $display("FAIL recover_restart: got %b expected 0", {fault, lamps});
        end
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        for (int j = 0; j < 2; j++) tick();
        set_r(2'b10, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, lamps} !== {1'b0, 8'h80}) begin
            tests_failed++;
            $display("FAIL recover_restart_resume: got %b expected %b",
                     {fault, lamps}, {1'b0, 8'h80});
        end
    endtask

    task automatic test_reset_in_flash();
        apply_reset();
        set_r(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        for (int j = 0; j < 5; j++) tick();
        tests_run++;
        if (lamps !== 8'hFF) begin
            tests_failed++;
            $display("FAIL flash_off_phase: got %h expected ff", lamps);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({fault, fault_code, fault_road, lamps} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_flash: got %b expected all zero",
                     {fault, fault_code, fault_road, lamps});
        end
`ifdef FAULT_COUNT_EN
        tests_run++;
        if (fault_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL fault_count_reset: got %0d expected 0", fault_count);
        end
`endif
        set_r(2'b10, 2'b00, 2'b00, 2'b00);
        tick();
        tests_run++;
        if ({fault, lamps} !== {1'b0, 8'h80}) begin
            tests_failed++;
            $display("FAIL green_after_reset: got %b expected %b", {fault, lamps}, {1'b0, 8'h80});
        end
    endtask

`ifdef FAULT_COUNT_EN
    task automatic test_fault_count();
        apply_reset();
        set_r(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++;
        if (fault_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL fault_count_after_clear: got %0d expected 1", fault_count);
        end
        for (int j = 0; j < 2; j++) tick();
        set_r(2'b10, 2'b00, 2'b10, 2'b00);
        tick();
        tests_run++;
        if (fault_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL fault_count_two: got %0d expected 2", fault_count);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        set_r(2'b00, 2'b00, 2'b00, 2'b00);
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_short_green();
        test_short_yellow_allred();
        test_bad_seq();
        test_recovery();
        test_recover_restart();
        test_reset_in_flash();
`ifdef FAULT_COUNT_EN
        test_fault_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
